mdl_req_sequencer: RTL and testbench

//  Queues MDL accounting requests from the partition/CPU side and drives them one at a time

---
 rtl/mdl_req_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_mdl_req_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_req_sequencer.sv
// Request sequencer for the MDL accounting unit: queues requests, issues them one at a time over a
// level req/ack handshake and reports each returned cost. Optional macro: MDL_SEQ_SKIP_ZERO_EN.
module mdl_req_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [5:0]                 in_module_id,
   input  logic [31:0]                in_module_size,
   input  logic                       in_consistent,
   output logic                       mdl_req,
   output logic [5:0]                 module_id,
   output logic [31:0]                module_size,
   output logic                       module_consistent,
   input  logic                       mdl_ack,
   input  logic [31:0]                mdl_cost,
   output logic                       cost_valid,
   output logic [5:0]                 cost_id,
   output logic [31:0]                cost_value,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [31:0]                seq_status,
   output logic                       seq_error
);

   // state  | meaning
   // S_IDLE | nothing in flight; pops the head whenever the queue is non-empty
   // S_REQ  | mdl_req high, waiting for mdl_ack=1 (or timeout)
   // S_REL  | cost captured, mdl_req low, waiting for mdl_ack=0 (or timeout)

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

   state_t           state;
   logic [38:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OW-1:0]    count;
   logic [38:0]      head;
   logic             full;
   logic             empty;
   logic             push;
   logic             store;
   logic             pop;
   logic             real_cost;
   logic             wait_expired;
   logic [WW-1:0]    wait_cnt;
   logic [15:0]      issued_cnt;
   logic [7:0]       timeout_cnt;
   logic             busy;

   assign full         = (count == OW'(DEPTH));
   assign empty        = (count == '0);
   assign head         = mem[rd_ptr];
   assign pop          = (state == S_IDLE) && !empty;
   assign push         = in_valid && in_ready;
   assign real_cost    = (state == S_REQ) && mdl_ack;
   assign wait_expired = (wait_cnt == WW'(TIMEOUT - 1));
   assign busy         = (state != S_IDLE);
   assign occupancy    = count;
   assign seq_status   = {issued_cnt, timeout_cnt, 5'b0, full, empty, busy};

`ifdef MDL_SEQ_SKIP_ZERO_EN
   logic       hold_valid;
   logic [5:0] hold_id;
   logic       zero_push;

   assign zero_push = push && (in_module_size == '0);
   assign store     = push && !zero_push;
   assign in_ready  = !full && !hold_valid;
`else
   assign store     = push;
   assign in_ready  = !full;
`endif

   // Storage array carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_ptr] <= {in_consistent, in_module_size, in_module_id};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + OW'(store) - OW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         mdl_req           <= 1'b0;
         module_id         <= '0;
         module_size       <= '0;
         module_consistent <= 1'b0;
         wait_cnt          <= '0;
         issued_cnt        <= '0;
         timeout_cnt       <= '0;
         seq_error         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  module_id         <= head[5:0];
                  module_size       <= head[37:6];
                  module_consistent <= head[38];
                  mdl_req           <= 1'b1;
                  wait_cnt          <= '0;
                  state             <= S_REQ;
               end
            end
            S_REQ: begin
               if (mdl_ack) begin
                  mdl_req    <= 1'b0;
                  issued_cnt <= issued_cnt + 16'd1;
                  wait_cnt   <= '0;
                  state      <= S_REL;
               end else if (wait_expired) begin
                  mdl_req     <= 1'b0;
                  seq_error   <= 1'b1;
                  timeout_cnt <= (timeout_cnt == 8'hFF) ? 8'hFF : timeout_cnt + 8'd1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_REL: begin
               if (!mdl_ack) begin
                  state <= S_IDLE;
               end else if (wait_expired) begin
                  seq_error   <= 1'b1;
                  timeout_cnt <= (timeout_cnt == 8'hFF) ? 8'hFF : timeout_cnt + 8'd1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            default: begin
               mdl_req <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // Cost reporting; cost_id uses the in-flight id before any new pop can replace it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cost_valid <= 1'b0;
         cost_id    <= '0;
         cost_value <= '0;
`ifdef MDL_SEQ_SKIP_ZERO_EN
         hold_valid <= 1'b0;
         hold_id    <= '0;
`endif
      end else begin
         cost_valid <= 1'b0;
`ifdef MDL_SEQ_SKIP_ZERO_EN
         // A held zero result never meets a real cost: the cycle after a real cost is spent in S_REL.
         if (hold_valid) begin
            cost_valid <= 1'b1;
            cost_id    <= hold_id;
            cost_value <= '0;
            hold_valid <= 1'b0;
         end else if (real_cost) begin
            cost_valid <= 1'b1;
            cost_id    <= module_id;
            cost_value <= mdl_cost;
            if (zero_push) begin
               hold_valid <= 1'b1;
               hold_id    <= in_module_id;
            end
         end else if (zero_push) begin
            cost_valid <= 1'b1;
            cost_id    <= in_module_id;
            cost_value <= '0;
         end
`else
         if (real_cost) begin
            cost_valid <= 1'b1;
            cost_id    <= module_id;
            cost_value <= mdl_cost;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mdl_req_sequencer.sv
// Directed bench for mdl_req_sequencer: scoreboarded costs from a responding accounting-unit model.
module tb_mdl_req_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_module_id;
   logic [31:0] in_module_size;
   logic        in_consistent;
   logic        mdl_req;
   logic [5:0]  module_id;
   logic [31:0] module_size;
   logic        module_consistent;
   logic        mdl_ack = 1'b0;
   logic [31:0] mdl_cost = 32'hDEADBEEF;
   logic        cost_valid;
   logic [5:0]  cost_id;
   logic [31:0] cost_value;
   logic [3:0]  occupancy;
   logic [31:0] seq_status;
   logic        seq_error;

   typedef struct packed {
      logic [5:0]  id;
      logic [31:0] cost;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cost_seen = 0;
   logic ack_en = 1'b0;

   always #5 clk = ~clk;

   mdl_req_sequencer #(.DEPTH(8), .TIMEOUT(16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_module_id      (in_module_id),
      .in_module_size    (in_module_size),
      .in_consistent     (in_consistent),
      .mdl_req           (mdl_req),
      .module_id         (module_id),
      .module_size       (module_size),
      .module_consistent (module_consistent),
      .mdl_ack           (mdl_ack),
      .mdl_cost          (mdl_cost),
      .cost_valid        (cost_valid),
      .cost_id           (cost_id),
      .cost_value        (cost_value),
      .occupancy         (occupancy),
      .seq_status        (seq_status),
      .seq_error         (seq_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Accounting-unit model: cost = size/4, valid only while ack is high.
   always @(negedge clk) begin
      mdl_ack  = ack_en & mdl_req;
      mdl_cost = mdl_ack ? (module_size >> 2) : 32'hDEADBEEF;
   end

   always @(negedge clk) begin
      if (rst_n && cost_valid) begin
         cost_seen++;
         check("cost_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("cost_id", 32'(cost_id), 32'(e.id));
            check("cost_value", cost_value, e.cost);
         end
      end
   end

   task automatic push(input logic [5:0] id, input logic [31:0] size, input logic cons,
                       input bit expect_cost, output bit accepted);
      in_valid       = 1'b1;
      in_module_id   = id;
      in_module_size = size;
      in_consistent  = cons;
      accepted       = in_ready;
      if (accepted && expect_cost) sb.push_back('{id: id, cost: size >> 2});
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(sb.size() == 0 && seq_status[0] == 1'b0 && occupancy == 4'd0 && !mdl_ack) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
   endtask

   initial begin
      bit acc;
      int n;
      int issued_exp;
      int seen0;
      in_valid       = 1'b0;
      in_module_id   = '0;
      in_module_size = '0;
      in_consistent  = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_status", seq_status, 32'h0000_0002);
      check("rst_mdl_req", 32'(mdl_req), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_cost_valid", 32'(cost_valid), 32'd0);
      check("rst_seq_error", 32'(seq_error), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single request, responsive unit
      ack_en = 1'b1;
      push(6'd3, 32'd16, 1'b1, 1'b1, acc);
      check("t1_req_not_yet", 32'(mdl_req), 32'd0);
      @(negedge clk);
      check("t1_req_high", 32'(mdl_req), 32'd1);
      check("t1_module_id", 32'(module_id), 32'd3);
      check("t1_module_size", module_size, 32'd16);
      check("t1_module_cons", 32'(module_consistent), 32'd1);
      wait_idle("t1_drain");
      check("t1_issued", 32'(seq_status[31:16]), 32'd1);

      // fill the queue behind a stalled request
      ack_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         push(6'(10 + i), 32'(64 + 4 * i), 1'(i), 1'b1, acc);
      end
      push(6'd40, 32'd400, 1'b0, 1'b1, acc);
      check("t2_tenth_dropped", 32'(acc), 32'd0);
      check("t2_occupancy", 32'(occupancy), 32'd8);
      check("t2_in_ready", 32'(in_ready), 32'd0);
      check("t2_full_bit", 32'(seq_status[2]), 32'd1);
      check("t2_req_held", 32'(mdl_req), 32'd1);
      ack_en = 1'b1;
      wait_idle("t2_drain");
      check("t2_issued", 32'(seq_status[31:16]), 32'd10);
      check("t2_no_error", 32'(seq_error), 32'd0);

      // timeout of an unanswered request
      ack_en = 1'b0;
      push(6'd20, 32'd100, 1'b0, 1'b0, acc);
      push(6'd7, 32'd40, 1'b1, 1'b1, acc);
      n = 0;
      while (mdl_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("t3_req_cycles", 32'(n), 32'd16);
      check("t3_seq_error", 32'(seq_error), 32'd1);
      check("t3_timeout_cnt", 32'(seq_status[15:8]), 32'd1);
      check("t3_busy", 32'(seq_status[0]), 32'd0);
      @(negedge clk);
      check("t3_next_req", 32'(mdl_req), 32'd1);
      check("t3_next_id", 32'(module_id), 32'd7);
      ack_en = 1'b1;
      wait_idle("t3_drain");
      check("t3_issued", 32'(seq_status[31:16]), 32'd11);
      check("t3_error_sticky", 32'(seq_error), 32'd1);

      // push coinciding with a pop from occupancy 1
      ack_en = 1'b0;
      push(6'd30, 32'd8, 1'b0, 1'b1, acc);
      push(6'd31, 32'd12, 1'b1, 1'b1, acc);
      check("t4_occ_before", 32'(occupancy), 32'd1);
      ack_en = 1'b1;
      n = 0;
      while (seq_status[0] && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("t4_idle_reached", 32'(n < 50), 32'd1);
      check("t4_occ_idle", 32'(occupancy), 32'd1);
      push(6'd32, 32'd20, 1'b0, 1'b1, acc);
      check("t4_occ_after", 32'(occupancy), 32'd1);
      check("t4_req", 32'(mdl_req), 32'd1);
      check("t4_issued_id", 32'(module_id), 32'd31);
      check("t4_issued_size", module_size, 32'd12);
      wait_idle("t4_drain");
      check("t4_issued", 32'(seq_status[31:16]), 32'd14);

      // irregular traffic
      issued_exp = 14;
      for (int i = 0; i < 6; i++) begin
         push(6'($urandom_range(0, 63)), 32'($urandom_range(1, 5000)), 1'($urandom_range(0, 1)), 1'b1, acc);
         if (acc) issued_exp++;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("rnd_drain");
      check("rnd_issued", 32'(seq_status[31:16]), 32'(issued_exp));

      // asynchronous reset in the middle of a request
      ack_en = 1'b0;
      push(6'd41, 32'd16, 1'b0, 1'b0, acc);
      push(6'd42, 32'd16, 1'b0, 1'b0, acc);
      check("t5_req_before", 32'(mdl_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_req_dropped", 32'(mdl_req), 32'd0);
      check("t5_occupancy", 32'(occupancy), 32'd0);
      check("t5_status", seq_status, 32'h0000_0002);
      check("t5_seq_error", 32'(seq_error), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // zero-size request
      ack_en = 1'b1;
      seen0 = cost_seen;
      push(6'd5, 32'd0, 1'b0, 1'b1, acc);
      check("t6_accepted", 32'(acc), 32'd1);
      wait_idle("t6_drain");
      check("t6_cost_count", 32'(cost_seen - seen0), 32'd1);
`ifdef MDL_SEQ_SKIP_ZERO_EN
      check("t6_issued", 32'(seq_status[31:16]), 32'd0);
`else
      check("t6_issued", 32'(seq_status[31:16]), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
